// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array and its drain/transmit path.
package systolic_pkg;

    localparam int ARRAY_SIZE  = 4;
    localparam int DATA_WIDTH  = 32;
    localparam int IFACE_WIDTH = 64;

    // Width of one full result row, also used by the array and drain logic.
    localparam int ROW_WIDTH   = ARRAY_SIZE * DATA_WIDTH;

    // Serialiser state encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock row queue with occupancy count; storage is not reset.
module sync_fifo #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic                  do_push;
    logic                  do_pop;

    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH);

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[head];

    // Row storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= (tail == LAST_SLOT) ? '0 : tail + 1'b1;
            end
            if (do_pop) begin
                head <= (head == LAST_SLOT) ? '0 : head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_output_buffer.sv
// Transmit path: queues result rows from the array and serialises each row
// into 64-bit words over a valid/ready handshake, low word first.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | no row in flight; loads the next row as soon as one is queued
//  ST_SEND | presenting shreg[63:0]; advances on out_ready, chains rows
module result_output_buffer #(
    parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
    parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   result_row,
    input  logic                               result_valid,
    output logic                               result_ready,
    output logic [systolic_pkg::IFACE_WIDTH-1:0] out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic [ADDR_WIDTH:0]                count,
    output logic                               idle
);

    import systolic_pkg::*;

    localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
    localparam int WORDS = ROW_W / IFACE_WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    ser_state_t        state;
    logic [ROW_W-1:0]  shreg;
    logic [IDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  idx_next;
    logic [ROW_W-1:0]  fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              row_done;

    assign result_ready = ~fifo_full;
    assign push         = result_valid & result_ready;
    assign row_done     = (state == ST_SEND) & out_ready & out_last;
    // Load a row either from idle or back-to-back when the last word leaves.
    assign pop          = ((state == ST_IDLE) | row_done) & ~fifo_empty;
    assign idx_next     = word_idx + IDX_W'(1);
    assign out_data     = shreg[IFACE_WIDTH-1:0];
    assign idle         = (state == ST_IDLE) & fifo_empty;

    sync_fifo #(
        .WIDTH      (ROW_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (result_row),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Serialiser FSM with registered handshake outputs and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            word_idx  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                if (!fifo_empty) begin
                    state     <= ST_SEND;
                    shreg     <= fifo_rd_data;
                    word_idx  <= '0;
                    out_valid <= 1'b1;
                    out_last  <= (WORDS == 1);
                end
            end else if (out_ready) begin
                if (!out_last) begin
                    shreg    <= shreg >> IFACE_WIDTH;
                    word_idx <= idx_next;
                    out_last <= (idx_next == LAST_IDX);
                end else if (!fifo_empty) begin
                    shreg    <= fifo_rd_data;
                    word_idx <= '0;
                    out_last <= (WORDS == 1);
                end else begin
                    // Clear the shifter so out_data reads zero while idle.
                    state     <= ST_IDLE;
                    shreg     <= '0;
                    word_idx  <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

endmodule
